// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snd_pkg
// Description : Shared types and default clip lengths for the sound-effect
//               event sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package snd_pkg;

  // Default one-shot clip lengths, in 8 kHz sample ticks
  localparam int TURN_LEN  = 8181;
  localparam int SCORE_LEN = 2693;
  localparam int HIT_LEN   = 6183;

  // Clip select codes seen by the playback block
  typedef enum logic [2:0] {
    CLIP_NONE  = 3'd0,
    CLIP_BG    = 3'd1,
    CLIP_TURN  = 3'd2,
    CLIP_SCORE = 3'd3,
    CLIP_HIT   = 3'd4
  } clip_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_READY = 3'd1,
    S_TURN  = 3'd2,
    S_SCORE = 3'd3,
    S_HIT   = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  // Clip presented downstream while sitting in a given state
  function automatic clip_e clip_of(input state_e s);
    case (s)
      S_MENU:  clip_of = CLIP_BG;
      S_TURN:  clip_of = CLIP_TURN;
      S_SCORE: clip_of = CLIP_SCORE;
      S_HIT:   clip_of = CLIP_HIT;
      default: clip_of = CLIP_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sfx_edge_det
// Description : Per-bit rising-edge detector with a registered one-clk pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_edge_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_prev;

  // Remember last level and register the 0->1 transition as a pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      rise   <= '0;
    end else begin
      r_prev <= din;
      rise   <= din & ~r_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfx_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sfx_event_sequencer
// Description : Arbitrates game events into a single clip command (select,
//               start, active, done) for the audio playback block, timing
//               one-shot clips in 8 kHz sample ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_event_sequencer
  import snd_pkg::*;
#(
  parameter int TURN_LEN  = snd_pkg::TURN_LEN,
  parameter int SCORE_LEN = snd_pkg::SCORE_LEN,
  parameter int HIT_LEN   = snd_pkg::HIT_LEN,
  parameter int CNT_W     = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_8k,
  input  logic [4:0] pbttn,
  input  logic       switch_screen,
  input  logic       gameover,
  input  logic       ate,
  output logic [2:0] clip_sel,
  output logic       clip_start,
  output logic       clip_active,
  output logic       clip_done
);

  localparam logic [CNT_W-1:0] c_turn_load  = CNT_W'(TURN_LEN - 1);
  localparam logic [CNT_W-1:0] c_score_load = CNT_W'(SCORE_LEN - 1);
  localparam logic [CNT_W-1:0] c_hit_load   = CNT_W'(HIT_LEN - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_score_pend;
  logic             r_start_pend;

  logic [4:0] w_btn_rise;
  logic       w_ate_req;
  logic       w_go_req;
  logic       w_turn_req;
  logic       w_tick_end;
  state_e     w_ready_tgt;
  logic       w_launch;
  state_e     w_launch_state;
  logic       w_end;
  logic [CNT_W-1:0] w_load;

  sfx_edge_det #(.WIDTH(5)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .din   (pbttn),
    .rise  (w_btn_rise)
  );

  sfx_edge_det #(.WIDTH(1)) u_ate_edge (
    .clk   (clk),
    .reset (reset),
    .din   (ate),
    .rise  (w_ate_req)
  );

  sfx_edge_det #(.WIDTH(1)) u_go_edge (
    .clk   (clk),
    .reset (reset),
    .din   (gameover),
    .rise  (w_go_req)
  );

  assign w_turn_req = |w_btn_rise;
  assign w_tick_end = tick_8k && (r_cnt == '0);

  // Decide whether a clip launches or ends this cycle, and which clip
  always_comb begin
    w_ready_tgt    = S_READY;
    w_launch       = 1'b0;
    w_launch_state = S_TURN;
    w_end          = 1'b0;

    // Idle-state request arbitration: HIT > SCORE > TURN
    if (w_go_req || gameover)          w_ready_tgt = S_HIT;
    else if (w_ate_req || r_score_pend) w_ready_tgt = S_SCORE;
    else if (w_turn_req)                w_ready_tgt = S_TURN;

    case (r_state)
      S_READY: begin
        if (w_ready_tgt != S_READY) begin
          w_launch       = 1'b1;
          w_launch_state = w_ready_tgt;
        end
      end
      S_TURN, S_SCORE: begin
        if (w_go_req || gameover) begin
          w_launch       = 1'b1;
          w_launch_state = S_HIT;
        end else if (w_tick_end) begin
          // Natural end: a coincident request is served as if from READY
          w_end = 1'b1;
          if (w_ready_tgt != S_READY) begin
            w_launch       = 1'b1;
            w_launch_state = w_ready_tgt;
          end
        end else if (w_ate_req) begin
          w_launch       = 1'b1;
          w_launch_state = S_SCORE;
        end else if (w_turn_req && (r_state == S_TURN)) begin
          w_launch       = 1'b1;
          w_launch_state = S_TURN;
        end
      end
      S_HIT: begin
        w_end = w_tick_end;
      end
      default: ;
    endcase

    case (w_launch_state)
      S_SCORE: w_load = c_score_load;
      S_HIT:   w_load = c_hit_load;
      default: w_load = c_turn_load;
    endcase
  end

  // Sequencer state machine with registered clip command outputs
  always_ff @(posedge clk) begin
    clip_start <= 1'b0;
    clip_done  <= 1'b0;
    if (reset) begin
      r_state      <= S_MENU;
      r_cnt        <= '0;
      r_score_pend <= 1'b0;
      r_start_pend <= 1'b1;
      clip_sel     <= CLIP_NONE;
      clip_active  <= 1'b0;
    end else if ((r_state != S_MENU) && !switch_screen) begin
      // Leaving the game screen aborts everything and restarts BG music
      r_state      <= S_MENU;
      r_score_pend <= 1'b0;
      clip_sel     <= CLIP_BG;
      clip_start   <= 1'b1;
      clip_active  <= 1'b0;
    end else if (w_launch) begin
      // Any clip start supersedes a queued score request
      r_state      <= w_launch_state;
      r_cnt        <= w_load;
      r_score_pend <= 1'b0;
      clip_sel     <= clip_of(w_launch_state);
      clip_start   <= 1'b1;
      clip_active  <= 1'b1;
      clip_done    <= w_end;
    end else if (w_end) begin
      r_state     <= (r_state == S_HIT) ? S_OVER : S_READY;
      clip_sel    <= CLIP_NONE;
      clip_active <= 1'b0;
      clip_done   <= 1'b1;
    end else begin
      case (r_state)
        S_MENU: begin
          if (r_start_pend) begin
            r_start_pend <= 1'b0;
            clip_sel     <= CLIP_BG;
            clip_start   <= 1'b1;
          end else if (switch_screen) begin
            r_state  <= S_READY;
            clip_sel <= CLIP_NONE;
          end else begin
            clip_sel <= CLIP_BG;
          end
        end
        S_OVER: begin
          if (!gameover) r_state <= S_READY;
        end
        S_TURN, S_SCORE, S_HIT: begin
          if (tick_8k) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sfx_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfx_event_sequencer
// Description : Directed self-checking bench for sfx_event_sequencer with a
//               scoreboard of expected clip_start / clip_done events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfx_event_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_8k;
  logic [4:0] pbttn;
  logic       switch_screen;
  logic       gameover;
  logic       ate;
  logic [2:0] clip_sel;
  logic       clip_start;
  logic       clip_active;
  logic       clip_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_done;
    logic [2:0] sel;
  } ev_t;

  ev_t exp_q[$];

  sfx_event_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .tick_8k       (tick_8k),
    .pbttn         (pbttn),
    .switch_screen (switch_screen),
    .gameover      (gameover),
    .ate           (ate),
    .clip_sel      (clip_sel),
    .clip_start    (clip_start),
    .clip_active   (clip_active),
    .clip_done     (clip_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_start(input logic [2:0] sel);
    ev_t e;
    e.is_done = 1'b0;
    e.sel     = sel;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.sel     = 3'd0;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input bit is_done, input logic [2:0] sel);
    ev_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL sb_unexpected observed=%s expected=none", is_done ? "done" : "start");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_kind_is_done", int'(is_done), int'(e.is_done));
      if (!is_done) chk("sb_start_sel", int'(sel), int'(e.sel));
    end
  endtask

  // Scoreboard monitor: every start/done pulse must match the next expectation
  always @(posedge clk) begin
    #1;
    if (clip_done)  check_ev(1'b1, 3'd0);
    if (clip_start) check_ev(1'b0, clip_sel);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick_8k = 1'b1;
    cyc(n);
    tick_8k = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_8k = 1'b0; pbttn = '0;
    switch_screen = 1'b0; gameover = 1'b0; ate = 1'b0;

    // Reset values
    cyc(3);
    chk("rst_sel", clip_sel, 0);
    chk("rst_start", clip_start, 0);
    chk("rst_active", clip_active, 0);
    chk("rst_done", clip_done, 0);

    // First cycle after release: BG start
    push_start(3'd1);
    reset = 1'b0;
    cyc(1);
    chk("boot_sel", clip_sel, 1);
    chk("boot_start", clip_start, 1);
    chk("boot_active", clip_active, 0);

    // Enter game screen
    switch_screen = 1'b1;
    cyc(1);
    chk("ready_sel", clip_sel, 0);

    // TURN clip, full length, two-cycle latency
    push_start(3'd2);
    pbttn = 5'b00100;
    cyc(1);
    pbttn = '0;
    chk("turn_lat_sel", clip_sel, 0);
    chk("turn_lat_start", clip_start, 0);
    cyc(1);
    chk("turn_sel", clip_sel, 2);
    chk("turn_active", clip_active, 1);
    ticks(8180);
    chk("turn_active_8180", clip_active, 1);
    chk("turn_done_8180", clip_done, 0);
    push_done();
    ticks(1);
    chk("turn_done_8181", clip_done, 1);
    chk("turn_end_active", clip_active, 0);
    chk("turn_end_sel", clip_sel, 0);

    // TURN preempted by ate at tick 100; launch-cycle tick not counted
    push_start(3'd2);
    pbttn = 5'b00001;
    cyc(1);
    pbttn = '0;
    cyc(1);
    chk("turn2_sel", clip_sel, 2);
    ticks(100);
    push_start(3'd3);
    ate = 1'b1;
    tick_8k = 1'b1;
    cyc(2);
    tick_8k = 1'b0;
    ate = 1'b0;
    chk("score_sel", clip_sel, 3);
    chk("score_start", clip_start, 1);
    ticks(2692);
    chk("score_active_2692", clip_active, 1);
    chk("score_sel_2692", clip_sel, 3);

    // SCORE end coinciding with a button edge: done plus TURN launch
    push_done();
    push_start(3'd2);
    pbttn = 5'b00010;
    cyc(1);
    pbttn = '0;
    tick_8k = 1'b1;
    cyc(1);
    tick_8k = 1'b0;
    chk("end_req_done", clip_done, 1);
    chk("end_req_start", clip_start, 1);
    chk("end_req_sel", clip_sel, 2);
    chk("end_req_active", clip_active, 1);

    // ate preempts TURN, button in SCORE dropped, gameover preempts SCORE
    push_start(3'd3);
    ate = 1'b1;
    cyc(2);
    ate = 1'b0;
    chk("score2_sel", clip_sel, 3);
    ticks(10);
    pbttn = 5'b10000;
    cyc(1);
    pbttn = '0;
    cyc(1);
    chk("score_btn_drop_sel", clip_sel, 3);
    chk("score_btn_drop_start", clip_start, 0);
    ticks(40);
    push_start(3'd4);
    gameover = 1'b1;
    cyc(1);
    chk("hit_sel", clip_sel, 4);
    chk("hit_done_none", clip_done, 0);
    cyc(1);
    ticks(6182);
    chk("hit_active_6182", clip_active, 1);
    push_done();
    ticks(1);
    chk("hit_done", clip_done, 1);
    chk("over_sel", clip_sel, 0);
    chk("over_active", clip_active, 0);

    // Events in S_OVER are ignored and not queued
    pbttn = 5'b11111;
    ate = 1'b1;
    cyc(3);
    pbttn = '0;
    ate = 1'b0;
    cyc(2);
    chk("over_ign_sel", clip_sel, 0);
    gameover = 1'b0;
    cyc(1);
    push_start(3'd2);
    pbttn = 5'b01000;
    cyc(1);
    pbttn = '0;
    cyc(1);
    chk("post_over_turn_sel", clip_sel, 2);

    // Leave and re-enter the game screen from TURN
    push_start(3'd1);
    switch_screen = 1'b0;
    cyc(1);
    chk("menu_sel", clip_sel, 1);
    chk("menu_active", clip_active, 0);
    switch_screen = 1'b1;
    cyc(1);
    chk("ready2_sel", clip_sel, 0);

    // ate and gameover together: only HIT, nothing queued afterwards
    push_start(3'd4);
    ate = 1'b1;
    gameover = 1'b1;
    cyc(1);
    chk("sim_hit_sel", clip_sel, 4);
    cyc(1);
    ate = 1'b0;
    ticks(6182);
    push_done();
    ticks(1);
    chk("sim_over_sel", clip_sel, 0);
    gameover = 1'b0;
    cyc(6);
    chk("sim_no_score_sel", clip_sel, 0);
    chk("sim_no_score_active", clip_active, 0);

    // Mid-HIT screen drop: BG start, no done
    push_start(3'd4);
    gameover = 1'b1;
    cyc(1);
    chk("hit3_sel", clip_sel, 4);
    ticks(30);
    push_start(3'd1);
    switch_screen = 1'b0;
    cyc(1);
    chk("drop_sel", clip_sel, 1);
    chk("drop_start", clip_start, 1);
    chk("drop_active", clip_active, 0);
    chk("drop_done", clip_done, 0);
    gameover = 1'b0;
    cyc(1);
    switch_screen = 1'b1;
    cyc(1);

    // Reset mid-TURN
    push_start(3'd2);
    pbttn = 5'b00010;
    cyc(1);
    pbttn = '0;
    cyc(1);
    chk("turn4_sel", clip_sel, 2);
    ticks(5);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_sel", clip_sel, 0);
    chk("mid_rst_start", clip_start, 0);
    chk("mid_rst_active", clip_active, 0);
    chk("mid_rst_done", clip_done, 0);
    push_start(3'd1);
    reset = 1'b0;
    cyc(1);
    chk("reboot_sel", clip_sel, 1);
    chk("reboot_start", clip_start, 1);
    cyc(1);
    chk("reboot_ready_sel", clip_sel, 0);

    cyc(2);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
